conv_unit_ctrl: RTL and testbench
=================================

CONV_UNIT_CTRL -- requirements
Module: conv_unit_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, data and bias width; KW, default 3, kernel rows per column; CH_W, default 8, channel-count width; COL_W, default 10, column-count width.
REQ-002 Ports SHALL be `clk  in  1  rising-edge clock`, with one clock; and `rst  in  1  reset`, synchronous and active-high.
REQ-003 Port `start  in  1` SHALL be a single-cycle pulse that begins a layer; it is sampled only in IDLE.
REQ-004 Port `cfg_ch  in  CH_W` SHALL give the input channel count (1..2^CH_W-1); it is latched on start.
REQ-005 Port `cfg_cols  in  COL_W` SHALL give the column count (1..2^COL_W-1); it is latched on start.
REQ-006 Port `cfg_bias  in  DATA_WIDTH` SHALL give the bias; it is latched on start.
REQ-007 Ports `in_valid in 1`, `in_ready out 1` and `in_data in DATA_WIDTH` SHALL form the upstream pixel stream; a beat is in_valid && in_ready.
REQ-008 Ports `MA_en`, `T_en`, `T_sel` and `dv_in` SHALL be `out 1` each; `A_sel` SHALL be `out 2`; `d_in` and `bias` SHALL be `out DATA_WIDTH`. These are the conv_unit control and data inputs.
REQ-009 Ports `k_sel out 2`, `ch_idx out CH_W` and `col_idx out COL_W` SHALL give the beat position, used to address the L/M/R kernel memories.
REQ-010 Port `busy out 1` SHALL be high in every state except IDLE; port `done out 1` SHALL be a one-cycle pulse.

Function
REQ-011 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-012 IDLE SHALL go to CLEAR on start; start in any other state SHALL be ignored.
REQ-013 CLEAR SHALL last one cycle with MA_en=1, dv_in=0, A_sel=2 and T_en=0, zeroing the accumulator; it then goes to RUN.
REQ-014 In RUN, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-015 Counter order SHALL be k (0..KW-1) fastest, then ch (0..cfg_ch-1), then col (0..cfg_cols-1). Counters advance only on a beat.
REQ-016 Each RUN beat SHALL produce, one cycle later, MA_en=1, dv_in=1, d_in=in_data and bias=latched bias, plus k_sel/ch_idx/col_idx of that beat. Latency is exactly 1 cycle.
REQ-017 A_sel for a beat SHALL be: 2 when col=0, ch=0, k=0; 1 when col>=1, ch=0, k=1; 0 otherwise.
REQ-018 T_en for a beat SHALL be 1 only when col>=KW, ch=0 and k=1; T_sel SHALL be 1 at all times.
REQ-019 A RUN cycle without a beat SHALL produce, one cycle later, MA_en=0, dv_in=0, T_en=0 and A_sel=0. Counters and d_in SHALL hold.
REQ-020 The beat at k=KW-1, ch=cfg_ch-1, col=cfg_cols-1 SHALL be the last; RUN then goes to DRAIN.
REQ-021 DRAIN SHALL last one cycle with MA_en=1, dv_in=0, A_sel=1 and T_en=1, flushing the final column; it then goes to DONE.
REQ-022 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-023 When cfg_ch=1, the same beat is both first and last channel; the A_sel and T_en rules still apply.
REQ-024 When cfg_cols=1, no A_sel=1 and no T_en=1 SHALL occur in RUN.
REQ-025 Counters SHALL wrap to 0 at their terminal values, with no overflow beyond the configured limit.

Reset
REQ-026 On rst, state SHALL become IDLE. All counters SHALL be 0. MA_en, T_en, dv_in, in_ready, busy and done SHALL be 0. A_sel SHALL be 0 and T_sel SHALL be 1. d_in and bias SHALL be 0. k_sel, ch_idx and col_idx SHALL be 0.
REQ-027 rst in mid-layer SHALL abort immediately: the next cycle is IDLE with reset outputs, and no done is issued.
REQ-028 rst SHALL take priority over start and over any beat in the same cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the A_sel encodings (SEL_SELF=0, SEL_SHIFT=1, SEL_ZERO=2) and the default KW.
REQ-030 One sub-module, conv_ctrl_cnt, SHALL be used: a parameterised enable/terminal-count/wrap counter, instantiated for k, ch and col.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 Scenario: start with cfg_ch=2, cfg_cols=5, bias=16384, in_valid held 1 -> one CLEAR cycle, then 30 beats. A_sel=2 at beat 0. A_sel=1 at beats 7, 13, 19 and 25. T_en=1 at beats 19 and 25. Then DRAIN, then done, 33 cycles after start.
REQ-033 Scenario: the same run with in_valid low every third cycle -> MA_en and dv_in are 0 in the gap cycles, the control sequence is unchanged, and done is delayed by the number of gaps.
REQ-034 Scenario: cfg_ch=1, cfg_cols=1 -> beats have k_sel 0, 1, 2 with A_sel 2, 0, 0, no T_en in RUN, and DRAIN has T_en=1.
REQ-035 Scenario: rst asserted at beat 10 of the REQ-032 run -> the next cycle has busy=0 and MA_en=0, no done occurs, and a following start runs a full layer correctly.
REQ-036 Scenario: start pulsed while busy -> ignored, and the latched cfg_ch, cfg_cols and bias are unchanged.
REQ-037 Scenario: data check -> d_in equals in_data of the preceding beat on every dv_in=1 cycle, for the values 15360, 16896 and 51328.

Source files
------------

// File: rtl/conv_unit_ctrl_pkg.sv
// Shared types and constants for the conv_unit sequencer.
package conv_unit_ctrl_pkg;

  localparam int unsigned KW_DEFAULT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [1:0] SEL_SELF  = 2'd0;
  localparam logic [1:0] SEL_SHIFT = 2'd1;
  localparam logic [1:0] SEL_ZERO  = 2'd2;

endpackage

// File: rtl/conv_ctrl_cnt.sv
// Enable/terminal-count counter that wraps to zero after reaching i_last.
module conv_ctrl_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == i_last);
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/conv_unit_ctrl.sv
// Layer sequencer for conv_unit: walks k/ch/col over the pixel stream and
// issues registered accumulator controls one cycle after each state or beat.
module conv_unit_ctrl
  import conv_unit_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned KW         = KW_DEFAULT,
  parameter int unsigned CH_W       = 8,
  parameter int unsigned COL_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [COL_W-1:0]      cfg_cols,
  input  logic [DATA_WIDTH-1:0] cfg_bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  MA_en,
  output logic                  T_en,
  output logic                  T_sel,
  output logic                  dv_in,
  output logic [1:0]            A_sel,
  output logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] bias,
  output logic [1:0]            k_sel,
  output logic [CH_W-1:0]       ch_idx,
  output logic [COL_W-1:0]      col_idx,
  output logic                  busy,
  output logic                  done
);

  state_e r_state, w_state_d;

  logic [CH_W-1:0]       r_cfg_ch;
  logic [COL_W-1:0]      r_cfg_cols;
  logic [DATA_WIDTH-1:0] r_cfg_bias;

  logic                  r_in_ready, r_ma_en, r_t_en, r_t_sel, r_dv_in, r_busy, r_done;
  logic [1:0]            r_a_sel, r_k_sel;
  logic [DATA_WIDTH-1:0] r_d_in, r_bias;
  logic [CH_W-1:0]       r_ch_idx;
  logic [COL_W-1:0]      r_col_idx;

  logic                  w_ma_en, w_t_en, w_dv_in, w_busy, w_done, w_in_ready;
  logic [1:0]            w_a_sel, w_k_sel;
  logic [DATA_WIDTH-1:0] w_d_in, w_bias;
  logic [CH_W-1:0]       w_ch_idx;
  logic [COL_W-1:0]      w_col_idx;

  logic                  w_beat, w_clr;
  logic [1:0]            w_k_cnt;
  logic [CH_W-1:0]       w_ch_cnt;
  logic [COL_W-1:0]      w_col_cnt;
  logic                  w_k_wrap, w_ch_wrap, w_col_wrap;

  // r_in_ready mirrors (state == RUN), so a beat is only possible in RUN.
  assign w_beat = in_valid && r_in_ready;
  assign w_clr  = (r_state == StIdle);

  conv_ctrl_cnt #(.W(2)) u_cnt_k (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_clr),
    .i_en   (w_beat),
    .i_last (2'(KW - 1)),
    .o_cnt  (w_k_cnt),
    .o_wrap (w_k_wrap)
  );

  conv_ctrl_cnt #(.W(CH_W)) u_cnt_ch (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_clr),
    .i_en   (w_k_wrap),
    .i_last (r_cfg_ch - CH_W'(1)),
    .o_cnt  (w_ch_cnt),
    .o_wrap (w_ch_wrap)
  );

  conv_ctrl_cnt #(.W(COL_W)) u_cnt_col (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_clr),
    .i_en   (w_ch_wrap),
    .i_last (r_cfg_cols - COL_W'(1)),
    .o_cnt  (w_col_cnt),
    .o_wrap (w_col_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StClear;
      StClear: w_state_d = StRun;
      StRun:   if (w_col_wrap) w_state_d = StDrain;
      StDrain: w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ma_en   = 1'b0;
    w_dv_in   = 1'b0;
    w_t_en    = 1'b0;
    w_a_sel   = SEL_SELF;
    w_d_in    = r_d_in;
    w_bias    = r_bias;
    w_k_sel   = r_k_sel;
    w_ch_idx  = r_ch_idx;
    w_col_idx = r_col_idx;
    unique case (r_state)
      StClear: begin
        w_ma_en = 1'b1;
        w_a_sel = SEL_ZERO;
      end
      StRun: begin
        if (w_beat) begin
          w_ma_en   = 1'b1;
          w_dv_in   = 1'b1;
          w_d_in    = in_data;
          w_bias    = r_cfg_bias;
          w_k_sel   = w_k_cnt;
          w_ch_idx  = w_ch_cnt;
          w_col_idx = w_col_cnt;
          if (w_col_cnt == '0 && w_ch_cnt == '0 && w_k_cnt == 2'd0) begin
            w_a_sel = SEL_ZERO;
          end else if (w_col_cnt != '0 && w_ch_cnt == '0 && w_k_cnt == 2'd1) begin
            w_a_sel = SEL_SHIFT;
          end
          // Column output is valid once a full KW-wide window has shifted in.
          w_t_en = (w_col_cnt >= COL_W'(KW)) && (w_ch_cnt == '0) && (w_k_cnt == 2'd1);
        end
      end
      StDrain: begin
        w_ma_en = 1'b1;
        w_a_sel = SEL_SHIFT;
        w_t_en  = 1'b1;
      end
      default: ;
    endcase
    w_busy     = (w_state_d != StIdle);
    w_in_ready = (w_state_d == StRun);
    w_done     = (w_state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_ch   <= '0;
      r_cfg_cols <= '0;
      r_cfg_bias <= '0;
    end else if (r_state == StIdle && start) begin
      r_cfg_ch   <= cfg_ch;
      r_cfg_cols <= cfg_cols;
      r_cfg_bias <= cfg_bias;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_ma_en    <= 1'b0;
      r_t_en     <= 1'b0;
      r_t_sel    <= 1'b1;
      r_dv_in    <= 1'b0;
      r_a_sel    <= SEL_SELF;
      r_d_in     <= '0;
      r_bias     <= '0;
      r_k_sel    <= '0;
      r_ch_idx   <= '0;
      r_col_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready;
      r_ma_en    <= w_ma_en;
      r_t_en     <= w_t_en;
      r_t_sel    <= 1'b1;
      r_dv_in    <= w_dv_in;
      r_a_sel    <= w_a_sel;
      r_d_in     <= w_d_in;
      r_bias     <= w_bias;
      r_k_sel    <= w_k_sel;
      r_ch_idx   <= w_ch_idx;
      r_col_idx  <= w_col_idx;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign in_ready = r_in_ready;
  assign MA_en    = r_ma_en;
  assign T_en     = r_t_en;
  assign T_sel    = r_t_sel;
  assign dv_in    = r_dv_in;
  assign A_sel    = r_a_sel;
  assign d_in     = r_d_in;
  assign bias     = r_bias;
  assign k_sel    = r_k_sel;
  assign ch_idx   = r_ch_idx;
  assign col_idx  = r_col_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_conv_unit_ctrl.sv
// Scoreboard bench for conv_unit_ctrl: each driven cycle pushes the expected
// outputs of the following cycle; a negedge monitor pops and compares.
module tb_conv_unit_ctrl;
  import conv_unit_ctrl_pkg::*;

  localparam int KW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_ch = '0;
  logic [9:0]  cfg_cols = '0;
  logic [15:0] cfg_bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        MA_en, T_en, T_sel, dv_in, busy, done;
  logic [1:0]  A_sel, k_sel;
  logic [15:0] d_in, bias;
  logic [7:0]  ch_idx;
  logic [9:0]  col_idx;

  conv_unit_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_ch   (cfg_ch),
    .cfg_cols (cfg_cols),
    .cfg_bias (cfg_bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .MA_en    (MA_en),
    .T_en     (T_en),
    .T_sel    (T_sel),
    .dv_in    (dv_in),
    .A_sel    (A_sel),
    .d_in     (d_in),
    .bias     (bias),
    .k_sel    (k_sel),
    .ch_idx   (ch_idx),
    .col_idx  (col_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, rdy, done, ma, dv, t, tsel;
    logic [1:0]  asel, k;
    logic [7:0]  ch;
    logic [9:0]  col;
    logic [15:0] d, b;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t val;
  } sb_ent_t;

  sb_ent_t     sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          last_done_cyc = -1;
  logic [15:0] vals[3] = '{16'd15360, 16'd16896, 16'd51328};

  // Held-value model: what d_in/bias/indices should show when not refreshed.
  logic [15:0] m_d = '0, m_b = '0;
  logic [1:0]  m_k = '0;
  logic [7:0]  m_ch = '0;
  logic [9:0]  m_col = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t    act;
    sb_ent_t ent;
    act = {busy, in_ready, done, MA_en, dv_in, T_en, T_sel, A_sel, k_sel, ch_idx, col_idx,
           d_in, bias};
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ent = sb.pop_front();
      checks++;
      if (ent.cyc != cyc || act !== ent.val) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d (exp for %0d) act=%h exp=%h | ma %b/%b dv %b/%b t %b/%b asel %0d/%0d done %b/%b",
                 cyc, ent.cyc, act, ent.val, act.ma, ent.val.ma, act.dv, ent.val.dv,
                 act.t, ent.val.t, act.asel, ent.val.asel, act.done, ent.val.done);
      end
    end
  end

  function automatic exp_t mk(input bit bz, input bit rd, input bit dn, input bit ma,
                              input bit dv, input bit t, input logic [1:0] as);
    exp_t e;
    e = '{busy: bz, rdy: rd, done: dn, ma: ma, dv: dv, t: t, tsel: 1'b1, asel: as,
          k: m_k, ch: m_ch, col: m_col, d: m_d, b: m_b};
    return e;
  endfunction

  task automatic push(input int c, input exp_t e);
    sb_ent_t ent;
    ent.cyc = c;
    ent.val = e;
    sb.push_back(ent);
  endtask

  task automatic clear_model();
    m_d = '0; m_b = '0; m_k = '0; m_ch = '0; m_col = '0;
  endtask

  task automatic run_layer(input int nch, input int ncols, input logic [15:0] b,
                           input bit gap, input int abort_beat, input bit poke_start,
                           input bit fixed_data);
    int          k, ch, col, beat, run_cyc, gaps, start_cyc, done0;
    bit          last, aborted, t;
    logic [1:0]  as;
    logic [15:0] data;
    k = 0; ch = 0; col = 0; beat = 0; run_cyc = 0; gaps = 0;
    last = 0; aborted = 0;
    done0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; cfg_ch = 8'(nch); cfg_cols = 10'(ncols); cfg_bias = b; in_valid = 1'b0;
    start_cyc = cyc;
    push(cyc + 1, mk(1, 0, 0, 0, 0, 0, SEL_SELF));
    @(posedge clk); #1;
    start = 1'b0;
    cfg_ch = 8'($urandom_range(1, 255)); cfg_cols = 10'($urandom_range(1, 1023));
    cfg_bias = 16'($urandom);
    push(cyc + 1, mk(1, 1, 0, 1, 0, 0, SEL_ZERO));
    while (!last && !aborted) begin
      @(posedge clk); #1;
      start = poke_start && (run_cyc == 4);
      if (start) begin
        cfg_ch = 8'd255; cfg_cols = 10'd1023; cfg_bias = 16'hffff;
      end
      in_valid = !(gap && (run_cyc % 3 == 2));
      data = fixed_data ? vals[beat % 3] : 16'($urandom);
      in_data = data;
      if (in_valid && beat == abort_beat) begin
        rst = 1'b1;
        aborted = 1;
        clear_model();
        push(cyc + 1, mk(0, 0, 0, 0, 0, 0, SEL_SELF));
      end else if (in_valid) begin
        m_d = data; m_b = b; m_k = 2'(k); m_ch = 8'(ch); m_col = 10'(col);
        last = (k == KW - 1) && (ch == nch - 1) && (col == ncols - 1);
        as = (col == 0 && ch == 0 && k == 0) ? SEL_ZERO :
             (col >= 1 && ch == 0 && k == 1) ? SEL_SHIFT : SEL_SELF;
        t = (col >= KW) && (ch == 0) && (k == 1);
        push(cyc + 1, mk(1, !last, 0, 1, 1, t, as));
        beat++;
        if (k == KW - 1) begin
          k = 0;
          if (ch == nch - 1) begin ch = 0; col++; end
          else ch++;
        end else k++;
      end else begin
        gaps++;
        push(cyc + 1, mk(1, 1, 0, 0, 0, 0, SEL_SELF));
      end
      run_cyc++;
    end
    if (aborted) begin
      repeat (5) begin
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        push(cyc + 1, mk(0, 0, 0, 0, 0, 0, SEL_SELF));
      end
      @(negedge clk); #1;
      checks++;
      if (done_cnt !== done0) begin
        errors++;
        $display("FAIL abort_no_done done pulses=%0d required=0", done_cnt - done0);
      end
    end else begin
      @(posedge clk); #1;
      push(cyc + 1, mk(1, 0, 1, 1, 0, 1, SEL_SHIFT));
      @(posedge clk); #1;
      in_valid = 1'b0;
      push(cyc + 1, mk(0, 0, 0, 0, 0, 0, SEL_SELF));
      @(negedge clk); #1;
      checks++;
      if (last_done_cyc !== start_cyc + 3 + nch * ncols * KW + gaps) begin
        errors++;
        $display("FAIL done_latency got cycle %0d required %0d", last_done_cyc - start_cyc,
                 3 + nch * ncols * KW + gaps);
      end
      checks++;
      if (done_cnt !== done0 + 1) begin
        errors++;
        $display("FAIL done_count got %0d required 1", done_cnt - done0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = (i == 1);
      cfg_ch = 8'd2; cfg_cols = 10'd2; in_valid = 1'b1;
      push(cyc + 1, mk(0, 0, 0, 0, 0, 0, SEL_SELF));
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    push(cyc + 1, mk(0, 0, 0, 0, 0, 0, SEL_SELF));
    @(posedge clk); #1;
    push(cyc + 1, mk(0, 0, 0, 0, 0, 0, SEL_SELF));
  endtask

  task automatic test_basic();
    run_layer(2, 5, 16'd16384, 0, -1, 0, 0);
  endtask

  task automatic test_gaps();
    run_layer(2, 5, 16'd16384, 1, -1, 0, 0);
  endtask

  task automatic test_single();
    run_layer(1, 1, 16'h0abc, 0, -1, 0, 0);
  endtask

  task automatic test_abort();
    run_layer(2, 5, 16'd16384, 0, 10, 0, 0);
    run_layer(2, 5, 16'd16384, 0, -1, 0, 0);
  endtask

  task automatic test_busy_start();
    run_layer(2, 5, 16'h1234, 0, -1, 1, 0);
  endtask

  task automatic test_data();
    run_layer(3, 2, 16'h4000, 1, -1, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_layer(1, 4, 16'h0001, 0, -1, 0, 0);
    run_layer(2, 1, 16'h0002, 0, -1, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_single();
    test_abort();
    test_busy_start();
    test_data();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end

endmodule
